// File: rtl/dmem_responder_if.sv
// Data-side bus between the core's MEM stage and the memory responder.
// Signal names follow the core's existing MEM-stage port names.
interface dmem_responder_if;
  logic        memCe;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memwriteData;
  logic [31:0] data_DataMem;

  modport master (output memCe, memWrite, memAddr, memwriteData, input data_DataMem);
  modport slave  (input memCe, memWrite, memAddr, memwriteData, output data_DataMem);
endinterface

// File: rtl/dmem_responder.sv
// Data RAM, memory-mapped timer and external-interrupt latch behind the core's
// MEM-stage port; also drives the core's intr lines.
module dmem_responder #(
  parameter int          RAM_AW = 10,
  parameter logic [31:0] DEV_ID = 32'h4D49_5053
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  input  logic [4:0]        ext_irq,
  output logic [5:0]        intr
);

  logic              mmio_sel, wr_en, ram_we;
  logic [2:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_tcnt, wr_tcmp, wr_tctrl, wr_ipend, wr_imask;
  logic              timer_match;
  logic [4:0]        irq_edge;

  logic [31:0] ram_q [0:(1<<RAM_AW)-1];

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;
  logic        tpend_q, tpend_d;
  logic [4:0]  ipend_q, ipend_d;
  logic [4:0]  imask_q, imask_d;
  logic [4:0]  sync1_q, sync2_q, prev_q;
  logic [5:0]  intr_q;

  wire unused_addr_bits = ^{bus.memAddr[27:RAM_AW+2], bus.memAddr[1:0]};

  assign mmio_sel = (bus.memAddr[31:28] == 4'h1);
  assign off      = bus.memAddr[4:2];
  assign ram_idx  = bus.memAddr[RAM_AW+1:2];
  assign wr_en    = bus.memCe & bus.memWrite;
  assign ram_we   = wr_en & ~mmio_sel;
  assign wr_tcnt  = wr_en & mmio_sel & (off == 3'd0);
  assign wr_tcmp  = wr_en & mmio_sel & (off == 3'd1);
  assign wr_tctrl = wr_en & mmio_sel & (off == 3'd2);
  assign wr_ipend = wr_en & mmio_sel & (off == 3'd3);
  assign wr_imask = wr_en & mmio_sel & (off == 3'd4);

  // A core write to TCNT takes priority and suppresses the compare that cycle.
  assign timer_match = tctrl_q[0] & (tcnt_q == tcmp_q) & ~wr_tcnt;
  assign irq_edge    = sync2_q & ~prev_q;

  always_comb begin
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    tpend_d = tpend_q;
    ipend_d = ipend_q;
    imask_d = imask_q;
    if (wr_tcnt)
      tcnt_d = bus.memwriteData;
    else if (tctrl_q[0])
      tcnt_d = (timer_match && tctrl_q[1]) ? 32'd0 : tcnt_q + 32'd1;
    if (wr_tcmp)  tcmp_d  = bus.memwriteData;
    if (wr_tctrl) tctrl_d = bus.memwriteData[1:0];
    if (wr_imask) imask_d = bus.memwriteData[4:0];
    if (wr_tctrl && bus.memwriteData[2]) tpend_d = 1'b0;
    if (timer_match) tpend_d = 1'b1;
    if (wr_ipend) ipend_d = ipend_q & ~bus.memwriteData[4:0];
    ipend_d = ipend_d | irq_edge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      tctrl_q <= '0;
      tpend_q <= 1'b0;
      ipend_q <= '0;
      imask_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      intr_q  <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
      tpend_q <= tpend_d;
      ipend_q <= ipend_d;
      imask_q <= imask_d;
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      intr_q  <= {tpend_q, ipend_q & imask_q};
    end
  end

  // RAM has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.memwriteData;
  end

  always_comb begin
    bus.data_DataMem = '0;
    if (bus.memCe) begin
      if (mmio_sel) begin
        case (off)
          3'd0:    bus.data_DataMem = tcnt_q;
          3'd1:    bus.data_DataMem = tcmp_q;
          3'd2:    bus.data_DataMem = {29'd0, tpend_q, tctrl_q};
          3'd3:    bus.data_DataMem = {27'd0, ipend_q};
          3'd4:    bus.data_DataMem = {27'd0, imask_q};
          3'd5:    bus.data_DataMem = DEV_ID;
          default: bus.data_DataMem = '0;
        endcase
      end else begin
        bus.data_DataMem = ram_q[ram_idx];
      end
    end
  end

  assign intr = intr_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side bus responder for the single-cycle MIPS core's MEM-stage port (memCe / memWrite / memAddr / memwriteData / read data).
- Contains a word-addressed data RAM, a memory-mapped timer and an external-interrupt latch.
- Drives the core's 6-bit intr input, completing the core's data and interrupt interfaces from the memory side.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- DEV_ID, 32'h4D49_5053, constant returned by the ID register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- memCe  input  1  access enable from the core.
- memWrite  input  1  1 = write, 0 = read; ignored when memCe=0.
- memAddr  input  32  byte address; bits [1:0] ignored (word accesses only).
- memwriteData  input  32  write data.
- data_DataMem  output  32  read data, combinational from the address in the same cycle.
- ext_irq  input  5  asynchronous external interrupt lines, active-high.
- intr  output  6  interrupt requests to the core.

Behaviour:
- Address decode:
  - memAddr[31:28]==4'h1 selects MMIO; offset is memAddr[4:2].
  - Any other value selects RAM; index is memAddr[RAM_AW+1:2]. Higher bits are ignored, so the address aliases (wraps).
- Reads:
  - Combinational, zero latency.
  - memCe=0 forces data_DataMem=0.
  - A read during a write cycle returns the old (pre-edge) contents.
- Writes: take effect on the rising edge when memCe=1 and memWrite=1.
- RAM contents are not reset. All MMIO state and intr reset to 0.
- MMIO map (offset: register):
  - 0 TCNT, R/W, 32-bit timer count.
  - 1 TCMP, R/W, compare value.
  - 2 TCTRL: bit0 EN, bit1 AUTORELOAD (both R/W); bit2 TPEND (read; write 1 clears); other bits read 0.
  - 3 IPEND: bits[4:0] latched external edges (read; write 1 clears).
  - 4 IMASK: bits[4:0] R/W.
  - 5 ID: read-only, returns DEV_ID.
  - 6-7: read 0, writes ignored.
- Timer, evaluated each cycle with EN=1:
  - TCNT==TCMP: set TPEND; next TCNT = 0 if AUTORELOAD else TCNT+1.
  - Otherwise: TCNT+1, wrapping modulo 2^32.
  - EN=0: TCNT holds and no match is evaluated.
- Timer collisions:
  - A core write to TCNT in the same cycle overrides the increment/reload; no match is raised that cycle.
  - A write-1-clear of TPEND in the same cycle as a new match leaves TPEND=1 (set wins).
- External interrupts:
  - Each ext_irq bit passes through a 2-flop synchronizer, then a rising-edge detector (a third flop holds the previous value).
  - A detected edge sets the matching IPEND bit.
  - Edge-to-IPEND latency is 3 clk edges after the input rises.
  - Set wins over a same-cycle write-1-clear.
  - Levels held high raise only one edge.
- Interrupt outputs (registered, one cycle after the pending/mask state changes):
  - intr[4:0] = IPEND & IMASK.
  - intr[5] = TPEND.
- Reset asserted mid-operation: synchronizer flops, pending bits, timer and intr clear immediately (asynchronously); RAM is left undisturbed.

Test Plan:
- Reset with rst=1, then release; read every MMIO offset -> all 0 except ID = 32'h4D49_5053; intr = 6'b0.
- Write 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 and alias 0x0000_1010 (RAM_AW=10) -> both return DEADBEEF; during the write cycle the read returns the old value.
- TCMP=3, TCTRL=3 (EN, AUTORELOAD) -> TCNT runs 0,1,2,3,0 and TPEND sets on the cycle after TCNT==3; intr[5]=1 one cycle later; writing TCTRL=4|3 clears it.
- TCMP=2, TCTRL=1 (no AUTORELOAD) -> TCNT continues 3,4…; write TCNT=32'hFFFF_FFFF -> next value 0; TPEND set once at the match.
- ext_irq[2] pulses for 1 cycle with IMASK=5'b00100 -> IPEND[2]=1 after 3 edges and intr[2]=1 one cycle later; with IMASK=0, IPEND sets but intr stays 0; W1C with a coincident new edge -> bit stays 1.
- Assert rst asynchronously mid-count with TPEND=1 -> TCNT, TPEND and intr go to 0 without waiting for a clock edge; a previously written RAM word still reads back intact.
